alu_cmd_fifo_engine: RTL
========================

# alu_cmd_fifo_engine

AXI4-Lite register-mapped compute engine that sits directly behind the OCL endpoint wrapper on `clk_main_a0`. The host writes operands and an opcode, which push a command into an input FIFO. A one-stage ALU pipeline drains that FIFO into a result FIFO, and the host pops results by reading a register. Status, sticky error flags and an activity summary are exposed over AXI-L and on the virtual LEDs.

## Interface
- `DEPTH`, 16, entries per FIFO; power of two, 2..128.
- `clk_main_a0` in 1: sole clock.
- `rst_main_n_sync` in 1: asynchronous, active-low reset.
- `awvalid`/`awready` in/out 1, `awaddr` in 32: write address channel.
- `wvalid`/`wready` in/out 1, `wdata` in 32, `wstrb` in 4: write data channel; `wstrb` ignored (full-word writes only).
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response.
- `arvalid`/`arready` in/out 1, `araddr` in 32: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2: read data.
- `debug_in` in 16: vDIP; bit0 = ALU pause, other bits ignored.
- `debug_out` out 16: vLED summary.

## Operation
- Decode `addr[7:0]`; upper bits ignored. Register map:
  - 0x00 OPA (RW).
  - 0x04 OPB (RW).
  - 0x08 CMD (W): pushes {`wdata[3:0]` opcode, OPA, OPB}.
  - 0x0C RESULT (R): pops the result FIFO.
  - 0x10 STATUS (R).
  - 0x14 CTRL (W): bit0 = clear.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL by B[4:0], 6 SRL by B[4:0].
  - 7 SLTU (result 1/0).
  - 8..15 reserved: result 0, sticky `bad_op` set.
- All arithmetic is 32-bit modulo 2^32; carries are discarded.
- ALU issue condition: input FIFO non-empty, `!debug_in[0]`, and `out_count + stage_valid < DEPTH`.
  - On issue: pop the head and load the result into the stage register.
  - Stage register writes the result FIFO on the next cycle.
- CMD write with the input FIFO full: command dropped, sticky `ovf` set, `bresp`=2'b10.
- RESULT read with the result FIFO empty: `rdata`=0, sticky `unf` set, `rresp`=2'b10.
- Other accesses: OKAY. Unmapped reads return 0; unmapped writes have no effect.
- STATUS fields:
  - [7:0] `in_count`, [15:8] `out_count`.
  - [16] `in_full`, [17] `out_empty`.
  - [18] `ovf`, [19] `unf`, [20] `bad_op`; others 0.
- CTRL bit0=1:
  - empties both FIFOs, invalidates the stage register, clears sticky flags and the done counter;
  - OPA/OPB are kept;
  - clear wins over any same-cycle push, pop or ALU write.
- `debug_out` is registered:
  - [7:0] completed-op counter, wraps at 255.
  - [8] `in_full`, [9] `out_empty`, [10] `ovf`, [11] `unf`, [12] `bad_op`.
  - [15:13] 0.

## Timing
- Reset values:
  - `awready`/`wready`/`arready` = 1.
  - `bvalid`/`rvalid` = 0, `bresp`/`rresp`/`rdata` = 0.
  - FIFOs empty, OPA/OPB = 0, flags = 0, `debug_out` = 16'h0200 (`out_empty`).
- Write channel:
  - AW and W are accepted independently; each ready drops after its handshake.
  - When both are held, the write takes effect and `bvalid` asserts on the next edge.
  - Both readies return high on the cycle after the `bvalid`&&`bready` handshake.
  - One write is outstanding at a time.
- Read channel:
  - `arready` = !`rvalid`. On AR handshake in cycle N, `rvalid` and `rdata` are registered at N+1 and held until `rready`.
  - The RESULT pop occurs at the AR handshake.
- CMD latency:
  - Write effective in cycle N → `in_count` increments at N+1.
  - Earliest issue is at N+1; result in the FIFO at N+2.
  - An AR accepted at N+3 returns it.
- A same-cycle ALU push and host pop on the result FIFO are both honoured; the count is unchanged.
- A same-cycle CMD push and ALU pop on the input FIFO are both honoured.
- Pause takes effect on the cycle after `debug_in[0]` rises; an in-flight stage result still completes.
- Reset asserted mid-transaction: all state returns to reset values immediately; the pending response is abandoned.

## Structure
- Package `alu_fifo_pkg`:
  - `alu_op_e` enum;
  - register offset localparams;
  - response codes `RESP_OKAY`/`RESP_SLVERR`;
  - command struct `alu_cmd_t` {op[3:0], a[31:0], b[31:0]}.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): push, pop, clear, count, full, empty, first-word-fall-through read data.
  - Instantiated twice: 68-bit command FIFO and 32-bit result FIFO.
- ALU combinational function and AXI-L front end live in the top module.

## Test plan
- OPA=5, OPB=3, CMD=0 then CMD=1; read RESULT twice → 8 then 0x00000002, OKAY; STATUS[17]=1 afterward.
- OPA=0xFFFFFFFF, OPB=1, CMD=0 → RESULT 0; CMD=7 with OPA=1, OPB=2 → RESULT 1; CMD=5 with OPB=0x24 → shift by 4.
- Set `debug_in[0]`=1, write DEPTH+1 CMDs → last returns `bresp` 2'b10, STATUS[7:0]=DEPTH, [18]=1; release pause → `out_count` reaches DEPTH, `in_count` 0.
- Read RESULT on empty → `rdata` 0, `rresp` 2'b10, STATUS[19]=1; write CTRL=1 → STATUS=0x00020000.
- CMD=9 → RESULT 0, `bad_op` set, `debug_out`[12]=1, `debug_out`[7:0]=1.
- Assert reset with `bvalid` pending and entries queued → after release `bvalid`=0, STATUS=0x00020000, `debug_out`=16'h0200.

Source files
------------

// File: rtl/alu_cmd_fifo_engine_pkg.sv
`default_nettype none
// ============================================================================
// alu_fifo_pkg : opcodes, register offsets, response codes and command type
// Rev 1.0
// ============================================================================
package alu_fifo_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLTU = 4'd7
  } alu_op_e;

  localparam logic [7:0] REG_OPA    = 8'h00;
  localparam logic [7:0] REG_OPB    = 8'h04;
  localparam logic [7:0] REG_CMD    = 8'h08;
  localparam logic [7:0] REG_RESULT = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;
  localparam logic [7:0] REG_CTRL   = 8'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo_engine_if.sv
`default_nettype none
// ============================================================================
// alu_cmd_fifo_engine_if : AXI4-Lite bus between the OCL wrapper and engine
// Rev 1.0
// ============================================================================
interface alu_cmd_fifo_engine_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo_engine_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with first-word-fall-through read data
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/alu_cmd_fifo_engine.sv
`default_nettype none
// ============================================================================
// alu_cmd_fifo_engine : AXI-Lite mapped ALU fed by a command FIFO, results FIFO
// Rev 1.0
// ============================================================================
module alu_cmd_fifo_engine
  import alu_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk_main_a0,
  input  logic                  rst_main_n_sync,
  alu_cmd_fifo_engine_if.slave  axil,
  input  logic [15:0]           debug_in,
  output logic [15:0]           debug_out
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;

  wr_state_e     wr_state;
  logic          awready_q, wready_q, bvalid_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;
  logic [7:0]    waddr;
  logic [31:0]   wdata_q;
  logic [31:0]   opa, opb;
  logic          pause_q, stage_valid, ovf, unf, bad_op;
  logic [31:0]   stage_data;
  logic [7:0]    done_cnt;

  alu_cmd_t      in_din, in_head;
  logic [31:0]   out_head;
  logic [CW-1:0] in_count, out_count;
  logic          in_full, in_empty, out_full, out_empty;
  logic          write_fire, clear, cmd_wr, in_push, issue;
  logic          ar_fire, rd_result, out_pop;
  logic [31:0]   status;
  logic          unused_ok;

  function automatic logic [31:0] alu_calc(input alu_cmd_t c);
    case (c.op)
      OP_ADD:  return c.a + c.b;
      OP_SUB:  return c.a - c.b;
      OP_AND:  return c.a & c.b;
      OP_OR:   return c.a | c.b;
      OP_XOR:  return c.a ^ c.b;
      OP_SLL:  return c.a << c.b[4:0];
      OP_SRL:  return c.a >> c.b[4:0];
      OP_SLTU: return {31'd0, c.a < c.b};
      default: return 32'd0;
    endcase
  endfunction

  assign write_fire = (wr_state == WR_IDLE) && !awready_q && !wready_q;
  assign clear      = write_fire && (waddr == REG_CTRL) && wdata_q[0];
  assign cmd_wr     = write_fire && (waddr == REG_CMD);
  assign in_push    = cmd_wr && !in_full;
  assign in_din     = '{op: wdata_q[3:0], a: opa, b: opb};
  assign ar_fire    = axil.arvalid && !rvalid_q;
  assign rd_result  = ar_fire && (axil.araddr[7:0] == REG_RESULT);
  assign out_pop    = rd_result && !out_empty;
  // Reserve a result slot for whatever is already sitting in the stage register
  assign issue      = !in_empty && !pause_q &&
                      ((out_count + CW'(stage_valid)) < CW'(DEPTH));
  assign status     = {11'd0, bad_op, unf, ovf, out_empty, in_full,
                       8'(out_count), 8'(in_count)};
  assign unused_ok  = &{1'b0, axil.wstrb, axil.awaddr[31:8], axil.araddr[31:8],
                        debug_in[15:1], out_full};

  assign axil.awready = awready_q;
  assign axil.wready  = wready_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.arready = !rvalid_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;

  sync_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(clk_main_a0), .rst_n(rst_main_n_sync), .clear(clear),
    .push(in_push), .din(in_din), .pop(issue), .dout(in_head),
    .count(in_count), .full(in_full), .empty(in_empty)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk_main_a0), .rst_n(rst_main_n_sync), .clear(clear),
    .push(stage_valid), .din(stage_data), .pop(out_pop), .dout(out_head),
    .count(out_count), .full(out_full), .empty(out_empty)
  );

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      wr_state  <= WR_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      waddr     <= '0;
      wdata_q   <= '0;
      opa       <= '0;
      opb       <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (awready_q && axil.awvalid) begin
            awready_q <= 1'b0;
            waddr     <= axil.awaddr[7:0];
          end
          if (wready_q && axil.wvalid) begin
            wready_q <= 1'b0;
            wdata_q  <= axil.wdata;
          end
          if (write_fire) begin
            wr_state <= WR_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= (cmd_wr && in_full) ? RESP_SLVERR : RESP_OKAY;
            if (waddr == REG_OPA) opa <= wdata_q;
            if (waddr == REG_OPB) opb <= wdata_q;
          end
        end
        WR_RESP: begin
          if (axil.bready) begin
            wr_state  <= WR_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= (rd_result && out_empty) ? RESP_SLVERR : RESP_OKAY;
      case (axil.araddr[7:0])
        REG_OPA:    rdata_q <= opa;
        REG_OPB:    rdata_q <= opb;
        REG_RESULT: rdata_q <= out_empty ? 32'd0 : out_head;
        REG_STATUS: rdata_q <= status;
        default:    rdata_q <= 32'd0;
      endcase
    end else if (rvalid_q && axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
    if (!rst_main_n_sync) begin
      pause_q     <= 1'b0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      bad_op      <= 1'b0;
      done_cnt    <= '0;
      debug_out   <= 16'h0200;
    end else begin
      pause_q   <= debug_in[0];
      debug_out <= {3'd0, bad_op, unf, ovf, out_empty, in_full, done_cnt};
      if (clear) begin
        stage_valid <= 1'b0;
        ovf         <= 1'b0;
        unf         <= 1'b0;
        bad_op      <= 1'b0;
        done_cnt    <= '0;
      end else begin
        stage_valid <= issue;
        if (issue) stage_data <= alu_calc(in_head);
        if (issue && in_head.op[3]) bad_op <= 1'b1;
        if (cmd_wr && in_full) ovf <= 1'b1;
        if (rd_result && out_empty) unf <= 1'b1;
        if (stage_valid) done_cnt <= done_cnt + 8'd1;
      end
    end
  end
endmodule
`default_nettype wire
